// File: rtl/ysyx_220066_alu_pkg.sv
// Shared definitions for the EX-stage ALU arbiter and its ALU control encoding.
package ysyx_220066_alu_pkg;

  localparam int XLEN  = 64;
  localparam int CTR_W = 5;

  // ALU function field, ctr[2:0]
  localparam logic [2:0] FN_ADD   = 3'o0;
  localparam logic [2:0] FN_SLL   = 3'o1;
  localparam logic [2:0] FN_SLT   = 3'o2;
  localparam logic [2:0] FN_PASSB = 3'o3;
  localparam logic [2:0] FN_XOR   = 3'o4;
  localparam logic [2:0] FN_SR    = 3'o5;
  localparam logic [2:0] FN_OR    = 3'o6;
  localparam logic [2:0] FN_AND   = 3'o7;

  // Modifier bits: ctr[3] = sub/arith/signed, ctr[4] = 32-bit word op
  localparam int SUB_BIT = 3;
  localparam int W_BIT   = 4;

  // Output register occupancy
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} resp_state_e;

endpackage

// File: rtl/ysyx_220066_rr_arb2.sv
// Two-way arbiter: round-robin on ties (RR_EN=1) or fixed priority to req[0].
// Kept standalone so other shared EX units can reuse it.
module ysyx_220066_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       grant
);

  logic last_grant;

  // Pick a requester; on a tie the one not served last time wins when RR is on
  always_comb begin
    grant = 1'b0;
    if (req == 2'b11)
      grant = RR_EN ? ~last_grant : 1'b0;
    else if (req[1])
      grant = 1'b1;
  end

  // Remember who was served; reset to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= 1'b1;
    else if (update)
      last_grant <= grant;
  end

endmodule

// File: rtl/ysyx_220066_alu_arbiter.sv
// Shares one combinational ALU between the integer execute path (req0) and the
// branch/compare path (req1). Results land in a single-entry response register.
module ysyx_220066_alu_arbiter
  import ysyx_220066_alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_a,
  input  logic [63:0]      req0_b,
  input  logic [4:0]       req0_ctr,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_a,
  input  logic [63:0]      req1_b,
  input  logic [4:0]       req1_ctr,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic [4:0]       alu_ctr,
  input  logic [63:0]      alu_result,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag,
  output logic [63:0]      resp_result,
  output logic             resp_zero
);

  resp_state_e state_q, state_d;
  logic        grant;
  logic        can_accept;
  logic        accept;

  ysyx_220066_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1_valid, req0_valid}),
    .update (accept),
    .grant  (grant)
  );

  // A slot is free if empty, or if the current response leaves this cycle
  assign can_accept = (state_q == EMPTY) | (resp_valid & resp_ready);
  assign req0_ready = can_accept & req0_valid & ~grant;
  assign req1_ready = can_accept & req1_valid &  grant;
  assign accept     = req0_ready | req1_ready;
  assign resp_valid = (state_q == FULL);

  // Steer the granted request onto the ALU; idle drives ADD 0+0
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = {2'b00, FN_ADD};
    if (req0_valid | req1_valid) begin
      alu_a   = grant ? req1_a   : req0_a;
      alu_b   = grant ? req1_b   : req0_b;
      alu_ctr = grant ? req1_ctr : req0_ctr;
    end
  end

  // Occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= EMPTY;
    else
      state_q <= state_d;
  end

  // Next occupancy: a load always fills; a drain without a load empties
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (resp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Capture the ALU outcome on accept; fields hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_id     <= 1'b0;
      resp_tag    <= '0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
    end else if (accept) begin
      resp_id     <= grant;
      resp_tag    <= grant ? req1_tag : req0_tag;
      resp_result <= alu_result;
      resp_zero   <= alu_zero;
    end
  end

endmodule

// File: tb/tb_ysyx_220066_alu_arbiter.sv
// Bench: round-robin instance (dut) and fixed-priority instance (dut_fp) share
// requester stimulus; each drives its own behavioural ALU.
module tb_ysyx_220066_alu_arbiter;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             req0_valid, req1_valid, resp_ready;
  logic [63:0]      req0_a, req0_b, req1_a, req1_b;
  logic [4:0]       req0_ctr, req1_ctr;
  logic [TAG_W-1:0] req0_tag, req1_tag;

  logic             req0_ready, req1_ready, resp_valid, resp_id, resp_zero, alu_zero;
  logic [63:0]      alu_a, alu_b, alu_result, resp_result;
  logic [4:0]       alu_ctr;
  logic [TAG_W-1:0] resp_tag;

  logic             req0_ready_fp, req1_ready_fp, resp_valid_fp, resp_id_fp, resp_zero_fp, alu_zero_fp;
  logic [63:0]      alu_a_fp, alu_b_fp, alu_result_fp, resp_result_fp;
  logic [4:0]       alu_ctr_fp;
  logic [TAG_W-1:0] resp_tag_fp;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (round-robin instance)
  bit               m_full, m_id, m_zero, m_last;
  logic [TAG_W-1:0] m_tag;
  logic [63:0]      m_res;

  ysyx_220066_alu_arbiter #(.TAG_W(TAG_W), .RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctr(req0_ctr), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctr(req1_ctr), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr), .alu_result(alu_result), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_tag(resp_tag),
    .resp_result(resp_result), .resp_zero(resp_zero)
  );

  ysyx_220066_alu_arbiter #(.TAG_W(TAG_W), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready_fp), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctr(req0_ctr), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready_fp), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctr(req1_ctr), .req1_tag(req1_tag),
    .alu_a(alu_a_fp), .alu_b(alu_b_fp), .alu_ctr(alu_ctr_fp), .alu_result(alu_result_fp),
    .alu_zero(alu_zero_fp),
    .resp_valid(resp_valid_fp), .resp_ready(resp_ready), .resp_id(resp_id_fp), .resp_tag(resp_tag_fp),
    .resp_result(resp_result_fp), .resp_zero(resp_zero_fp)
  );

  // Behavioural ALU: ctr[4]=word op, ctr[3]=sub/arith/signed, ctr[2:0]=function
  function automatic logic [63:0] alu_f(input logic [63:0] a, input logic [63:0] b, input logic [4:0] c);
    logic [63:0] r;
    logic [31:0] w;
    r = '0;
    case (c[2:0])
      3'o0: r = c[3] ? a - b : a + b;
      3'o1: r = c[4] ? (a << b[4:0]) : (a << b[5:0]);
      3'o2: if (c[3]) r = {63'd0, ($signed(a) < $signed(b))};
            else      r = {63'd0, (a < b)};
      3'o3: r = b;
      3'o4: r = a ^ b;
      3'o5: begin
        if (c[4]) begin
          if (c[3]) w = $signed(a[31:0]) >>> b[4:0];
          else      w = a[31:0] >> b[4:0];
          r = {32'd0, w};
        end else begin
          if (c[3]) r = $signed(a) >>> b[5:0];
          else      r = a >> b[5:0];
        end
      end
      3'o6: r = a | b;
      default: r = a & b;
    endcase
    if (c[4]) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  always_comb begin
    alu_result    = alu_f(alu_a, alu_b, alu_ctr);
    alu_zero      = (alu_result == 64'd0);
    alu_result_fp = alu_f(alu_a_fp, alu_b_fp, alu_ctr_fp);
    alu_zero_fp   = (alu_result_fp == 64'd0);
  end

  function automatic logic [63:0] rnd64();
    case ($urandom % 4)
      0:       return 64'($urandom % 8);
      1:       return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input bit v, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] c, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_a = a; req0_b = b; req0_ctr = c; req0_tag = t;
  endtask

  task automatic set_req1(input bit v, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] c, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_a = a; req1_b = b; req1_ctr = c; req1_tag = t;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; resp_ready = 1'b1;
    set_req0(0, 64'd0, 64'd0, 5'd0, 4'd0);
    set_req1(0, 64'd0, 64'd0, 5'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL reset_id got=%b exp=0", resp_id); end
    n_checks++; if (resp_tag !== 4'd0) begin n_fail++; $display("FAIL reset_tag got=%h exp=0", resp_tag); end
    n_checks++; if (resp_result !== 64'd0) begin n_fail++; $display("FAIL reset_result got=%h exp=0", resp_result); end
    n_checks++; if (resp_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got=%b exp=0", resp_zero); end
    n_checks++; if (resp_valid_fp !== 1'b0) begin n_fail++; $display("FAIL reset_valid_fp got=%b exp=0", resp_valid_fp); end
    rst_n = 1'b1;
  endtask

  task automatic test_req0_alone();
    step();
    resp_ready = 1'b1;
    set_req0(1, 64'd5, 64'd3, 5'b00000, 4'hA);
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL r0_ready got=%b exp=1", req0_ready); end
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL r0_r1ready got=%b exp=0", req1_ready); end
    n_checks++; if (alu_a !== 64'd5) begin n_fail++; $display("FAIL r0_alu_a got=%h exp=5", alu_a); end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL r0_valid got=%b exp=1", resp_valid); end
    n_checks++; if (resp_id !== 1'b0) begin n_fail++; $display("FAIL r0_id got=%b exp=0", resp_id); end
    n_checks++; if (resp_result !== 64'd8) begin n_fail++; $display("FAIL r0_result got=%h exp=8", resp_result); end
    n_checks++; if (resp_zero !== 1'b0) begin n_fail++; $display("FAIL r0_zero got=%b exp=0", resp_zero); end
    n_checks++; if (resp_tag !== 4'hA) begin n_fail++; $display("FAIL r0_tag got=%h exp=a", resp_tag); end
    n_checks++; if (alu_a !== 64'd0 || alu_ctr !== 5'd0) begin n_fail++; $display("FAIL idle_alu got=%h/%h exp=0/0", alu_a, alu_ctr); end
  endtask

  task automatic test_req1_alone();
    step();
    set_req1(1, 64'd7, 64'd7, 5'b01000, 4'h3);
    @(negedge clk);
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL r1_ready got=%b exp=1", req1_ready); end
    step();
    req1_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_result !== 64'd0) begin n_fail++; $display("FAIL r1_result got=%h exp=0", resp_result); end
    n_checks++; if (resp_zero !== 1'b1) begin n_fail++; $display("FAIL r1_zero got=%b exp=1", resp_zero); end
    n_checks++; if (resp_id !== 1'b1) begin n_fail++; $display("FAIL r1_id got=%b exp=1", resp_id); end
    n_checks++; if (resp_tag !== 4'h3) begin n_fail++; $display("FAIL r1_tag got=%h exp=3", resp_tag); end
  endtask

  task automatic test_rr_tie();
    bit exp_g;
    step();
    resp_ready = 1'b1;
    set_req0(1, 64'd1, 64'd2, 5'b00000, 4'h1);
    set_req1(1, 64'd10, 64'd4, 5'b01000, 4'h2);
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2) == 1;
      @(negedge clk);
      n_checks++; if (req0_ready !== !exp_g || req1_ready !== exp_g) begin
        n_fail++; $display("FAIL rr_grant cyc=%0d got=%b%b exp=%b%b", i, req1_ready, req0_ready, exp_g, !exp_g); end
      if (i > 0) begin
        n_checks++; if (resp_id !== !exp_g) begin n_fail++; $display("FAIL rr_id cyc=%0d got=%b exp=%b", i, resp_id, !exp_g); end
      end
      step();
    end
    @(negedge clk);
    n_checks++; if (resp_id !== 1'b1 || resp_result !== 64'd6) begin
      n_fail++; $display("FAIL rr_last got=%b/%h exp=1/6", resp_id, resp_result); end
  endtask

  task automatic test_fixed_prio();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (req0_ready_fp !== 1'b1 || req1_ready_fp !== 1'b0) begin
        n_fail++; $display("FAIL fp_grant cyc=%0d got=%b%b exp=01", i, req1_ready_fp, req0_ready_fp); end
      step();
    end
    @(negedge clk);
    n_checks++; if (resp_id_fp !== 1'b0 || resp_result_fp !== 64'd3 || resp_tag_fp !== 4'h1 || resp_zero_fp !== 1'b0) begin
      n_fail++; $display("FAIL fp_resp got=%b/%h/%h/%b exp=0/3/1/0", resp_id_fp, resp_result_fp, resp_tag_fp, resp_zero_fp); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    set_req0(1, 64'd9, 64'd1, 5'b00000, 4'h3);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    set_req0(1, 64'd2, 64'd1, 5'b00001, 4'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_ready cyc=%0d got=%b%b exp=00", i, req1_ready, req0_ready); end
      n_checks++; if (resp_valid !== 1'b1 || resp_result !== 64'd10 || resp_tag !== 4'h3) begin
        n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%h exp=1/a/3", i, resp_valid, resp_result, resp_tag); end
      n_checks++; if (alu_a !== 64'd2 || alu_ctr !== 5'b00001) begin
        n_fail++; $display("FAIL bp_alu cyc=%0d got=%h/%h exp=2/1", i, alu_a, alu_ctr); end
      step();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b exp=1", req0_ready); end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_result !== 64'd4 || resp_tag !== 4'h6) begin
      n_fail++; $display("FAIL bp_result got=%h/%h exp=4/6", resp_result, resp_tag); end
  endtask

  task automatic test_word_op();
    step();
    set_req0(1, 64'h7FFF_FFFF, 64'd1, 5'b10000, 4'h7);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_result !== 64'hFFFF_FFFF_8000_0000 || resp_zero !== 1'b0) begin
      n_fail++; $display("FAIL word_add got=%h/%b exp=ffffffff80000000/0", resp_result, resp_zero); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_q[$];
    step();
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req0(1, rnd64(), rnd64(), 5'($urandom), 4'(i));
      @(negedge clk);
      n_checks++; if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", i, req0_ready); end
      if (i > 0) begin
        n_checks++; if (resp_valid !== 1'b1 || resp_result !== exp_q[0] || resp_tag !== 4'(i - 1)) begin
          n_fail++; $display("FAIL b2b_resp cyc=%0d got=%b/%h/%h exp=1/%h/%h", i, resp_valid, resp_result, resp_tag, exp_q[0], 4'(i - 1)); end
        void'(exp_q.pop_front());
      end
      exp_q.push_back(alu_f(req0_a, req0_b, req0_ctr));
      step();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_result !== exp_q[0] || resp_tag !== 4'd7) begin
      n_fail++; $display("FAIL b2b_last got=%h/%h exp=%h/7", resp_result, resp_tag, exp_q[0]); end
  endtask

  task automatic test_random();
    bit acc0, acc1, g, can, e0, e1;
    logic [63:0] exp_a;
    do_reset();
    m_full = 0; m_id = 0; m_zero = 0; m_last = 1; m_tag = '0; m_res = '0;
    acc0 = 0; acc1 = 0;
    for (int n = 0; n < 300; n++) begin
      if (!req0_valid || acc0) begin
        set_req0(($urandom % 3) != 0, rnd64(), rnd64(), 5'($urandom), 4'($urandom));
        if ($urandom % 3 == 0) req0_b = req0_a;
      end
      if (!req1_valid || acc1) begin
        set_req1(($urandom % 3) != 0, rnd64(), rnd64(), 5'($urandom), 4'($urandom));
        if ($urandom % 3 == 0) req1_b = req1_a;
      end
      resp_ready = ($urandom % 4) != 0;
      @(negedge clk);
      if (req0_valid && req1_valid) g = !m_last;
      else g = req1_valid;
      can = !m_full || resp_ready;
      e0 = can && req0_valid && !g;
      e1 = can && req1_valid && g;
      exp_a = (req0_valid || req1_valid) ? (g ? req1_a : req0_a) : 64'd0;
      n_checks++; if (req0_ready !== e0 || req1_ready !== e1) begin
        n_fail++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp=%b%b", n, req1_ready, req0_ready, e1, e0); end
      n_checks++; if (resp_valid !== m_full) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, resp_valid, m_full); end
      n_checks++; if (resp_id !== m_id || resp_tag !== m_tag || resp_result !== m_res || resp_zero !== m_zero) begin
        n_fail++; $display("FAIL rnd_resp cyc=%0d got=%b/%h/%h/%b exp=%b/%h/%h/%b", n,
                           resp_id, resp_tag, resp_result, resp_zero, m_id, m_tag, m_res, m_zero); end
      n_checks++; if (alu_a !== exp_a) begin
        n_fail++; $display("FAIL rnd_alu_a cyc=%0d got=%h exp=%h", n, alu_a, exp_a); end
      acc0 = e0; acc1 = e1;
      @(posedge clk);
      if (e0 || e1) begin
        m_full = 1; m_id = g; m_last = g;
        m_tag  = g ? req1_tag : req0_tag;
        m_res  = g ? alu_f(req1_a, req1_b, req1_ctr) : alu_f(req0_a, req0_b, req0_ctr);
        m_zero = (m_res == 64'd0);
      end else if (m_full && resp_ready) begin
        m_full = 0;
      end
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    resp_ready = 1'b1;
    set_req0(1, 64'd20, 64'd22, 5'b00000, 4'h9);
    step();
    req0_valid = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b1 || resp_result !== 64'd42) begin
      n_fail++; $display("FAIL rm_full got=%b/%h exp=1/2a", resp_valid, resp_result); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (resp_valid !== 1'b0 || resp_result !== 64'd0) begin
      n_fail++; $display("FAIL rm_async got=%b/%h exp=0/0", resp_valid, resp_result); end
    @(negedge clk);
    rst_n = 1'b1; resp_ready = 1'b1;
    set_req0(1, 64'd1, 64'd1, 5'b00000, 4'h4);
    set_req1(1, 64'd3, 64'd3, 5'b01000, 4'h5);
    #1;
    n_checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL rm_first_tie got=%b%b exp=01", req1_ready, req0_ready); end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (resp_id !== 1'b0 || resp_result !== 64'd2 || resp_tag !== 4'h4) begin
      n_fail++; $display("FAIL rm_resp got=%b/%h/%h exp=0/2/4", resp_id, resp_result, resp_tag); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_req0_alone();
    test_req1_alone();
    test_rr_tie();
    test_fixed_prio();
    test_backpressure();
    test_word_op();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_220066_alu_arbiter.md
Name: ysyx_220066_alu_arbiter

Overview:
- Shares one combinational ALU (64-bit operands, 5-bit op control, 64-bit result, zero flag) between two requesters: req0 = integer execute path, req1 = branch/compare path.
- Arbitrates with valid/ready handshakes and drives the ALU from the granted request.
- Captures result and zero flag into a single-entry output register, then returns them with requester id and tag.
- Sits in the EX stage between issue logic and the shared ALU instance.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response
RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, req0 always wins

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  64  operand A
req0_b  input  64  operand B
req0_ctr  input  5  ALU control: [4]=word op, [3]=sub/arith/signed, [2:0]=function
req0_tag  input  TAG_W  opaque tag
req1_valid, req1_ready, req1_a, req1_b, req1_ctr, req1_tag  same widths and meaning, requester 1
alu_a  output  64  operand A to ALU
alu_b  output  64  operand B to ALU
alu_ctr  output  5  control to ALU
alu_result  input  64  ALU result, combinational from alu_a/alu_b/alu_ctr
alu_zero  input  1  ALU zero flag
resp_valid  output  1  response register holds data
resp_ready  input  1  consumer accepts response
resp_id  output  1  requester that issued the response
resp_tag  output  TAG_W  tag of that request
resp_result  output  64  captured ALU result
resp_zero  output  1  captured zero flag

Behaviour:
- Reset (rst_n low, asynchronous): resp_valid=0; resp_id, resp_tag, resp_result, resp_zero = 0; state=EMPTY; last_grant=1, so req0 wins the first tie.
- FSM, two states:
  - EMPTY (resp_valid=0).
  - FULL (resp_valid=1).
- can_accept = (state==EMPTY) | (resp_valid & resp_ready).
- Grant, combinational:
  - Only one req valid: grant it.
  - Both valid, RR_EN=1: grant the one != last_grant.
  - Both valid, RR_EN=0: grant req0.
- reqN_ready = can_accept & grant==N. Never assert both readys in one cycle. reqN_ready may depend combinationally on resp_ready.
- alu_a/b/ctr = granted request's fields while any req is valid; otherwise all-zero, which is ADD 0+0.
- Latency: an accepted request (valid&ready at edge) is visible on resp_* the next cycle, i.e. 1-cycle latency.
- On accept: resp_result<=alu_result, resp_zero<=alu_zero, resp_id<=grant, resp_tag<=tag, state<=FULL. last_grant updates to grant on accept only.
- On drain (resp_valid & resp_ready) with no accept: state<=EMPTY. The resp_* data fields hold their last values.
- Simultaneous drain and accept: state stays FULL and the new response is loaded. Full throughput is 1 op/cycle.
- FULL & !resp_ready: both readys=0. resp_* is held stable until accepted; the ALU inputs still follow the pending grant.
- Requesters hold valid and all fields stable until ready. The arbiter may change its grant only when no accept occurs, and only as a result of request-valid changes.
- Reset asserted mid-operation: the response is discarded. The requester re-presents after reset; no partial state survives.
- Starvation: with RR_EN=1 and both requesters continuously valid, grants strictly alternate.

Decomposition:
- Shared package ysyx_220066_alu_pkg:
  - Function codes: ADD=3'o0, SLL=3'o1, SLT=3'o2, PASSB=3'o3, XOR=3'o4, SR=3'o5, OR=3'o6, AND=3'o7.
  - Modifier bit indices: SUB_BIT=3, W_BIT=4.
  - FSM state enum: EMPTY, FULL.
- Sub-module ysyx_220066_rr_arb2: 2-way round-robin/fixed-priority grant with last_grant register. It is reused later for a shared multiplier.

Test Plan:
- Reset, then req0 alone: a=5, b=3, ctr=5'b00000 -> req0_ready=1 the same cycle; next cycle resp_valid=1, resp_id=0, resp_result=8, resp_zero=0, tag echoed.
- req1 alone: a=7, b=7, ctr=5'b01000 (SUB) -> resp_result=0, resp_zero=1, resp_id=1.
- Both valid for 4 cycles, resp_ready=1, RR_EN=1 -> grants 0,1,0,1. With RR_EN=0 -> grants 0,0,0,0 and req1 never ready.
- Backpressure: resp_ready=0 for 3 cycles with FULL -> both readys=0 and resp_* unchanged. On resp_ready=1 the pending req0 (a=2, b=1, ctr=5'b00001, SLL) is accepted the same cycle; next cycle resp_result=4.
- Word op via req0: a=64'h7FFF_FFFF, b=1, ctr=5'b10000 -> resp_result=64'hFFFF_FFFF_8000_0000. Back-to-back streaming at 1 response/cycle.
- Assert rst_n low while FULL -> resp_valid=0 immediately, without waiting for clk. After release, req0 wins the first tie.
